alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter OPCNT_W, default 8, width of the completed-operation counter.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  request strobe.
REQ-006 in_ready  output  1  request accept; transfer when in_valid & in_ready at a rising edge.
REQ-007 in_load  input  1  1 = load immediate, 0 = ALU operation.
REQ-008 in_op  input  3  ALU opcode, same encoding as the decode-and-execute sel.
REQ-009 in_dst / in_src1 / in_src2  input  2 each  register-file indices R0..R3.
REQ-010 in_imm  input  4  immediate for load.
REQ-011 alu_rs / alu_rt  output  4 each  operands to the external ALU.
REQ-012 alu_sel  output  3  opcode to the external ALU.
REQ-013 alu_rd  input  4  combinational ALU result.
REQ-014 out_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-015 out_data / out_dst  output  4 / 2  written value and register index.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 mismatch  output  1  sticky flag: ALU result differed from the internal model.
REQ-018 op_count  output  OPCNT_W  completed-request counter.

Function
REQ-019 The block SHALL hold four 4-bit registers R0..R3, all writable, including R0.
REQ-020 The FSM SHALL have states IDLE, READ, ISSUE, WRITE; in_ready = 1 only in IDLE.
REQ-021 For an ALU request accepted at edge N: IDLE->READ; at edge N+1 the block registers alu_rs=R[src1], alu_rt=R[src2], alu_sel=in_op (request fields captured at accept); READ->ISSUE.
REQ-022 In ISSUE, alu_rd SHALL be sampled at edge N+2; ISSUE->WRITE.
REQ-023 At edge N+3: R[dst] <= sampled result; out_valid=1, out_data=result, out_dst=dst for exactly that cycle; WRITE->IDLE.
REQ-024 A load request SHALL go IDLE->WRITE, write in_imm to R[dst] and pulse out_valid at edge N+1, with no ALU activity; alu_* outputs hold their previous values.
REQ-025 Operands SHALL be read before write-back; src equal to dst is legal and uses the old value.
REQ-026 Internal model, all 4-bit mod 16: 000 rs-rt; 001 rs+rt; 010 rs|rt; 011 rs&rt; 100 rt rotated right 1 ({rt[0],rt[3:1]}); 101 rs rotated left 1 ({rs[2:0],rs[3]}); 110 4'b1010+(rs<rt unsigned); 111 4'b1110+(rs==rt).
REQ-027 On the ISSUE sample, if alu_rd != model result, mismatch SHALL set and remain 1 until reset; the ALU value is still written back.
REQ-028 op_count SHALL increment by 1 on every out_valid pulse and wrap from 2^OPCNT_W-1 to 0.
REQ-029 in_valid outside IDLE SHALL be ignored; the next request is accepted no earlier than the edge after WRITE.
REQ-030 Unused or undefined request fields SHALL not affect behaviour.

Reset
REQ-031 rst SHALL force: state IDLE, R0..R3=0, alu_rs=alu_rt=0, alu_sel=0, out_valid=0, out_data=0, out_dst=0, mismatch=0, op_count=0, busy=0, in_ready=1 in the following cycle.
REQ-032 rst in any state, including mid-operation, SHALL abort the request with no register write and no out_valid pulse; rst takes priority over all other events.

Verification
REQ-033 Reset: rst high 2 cycles -> all outputs 0, in_ready=1, busy=0.
REQ-034 Load R1=7 and R2=3, then op 000 dst=3 src1=1 src2=2, bench ALU returns 4 -> alu_rs=7, alu_rt=3, alu_sel=000 in ISSUE; out_valid at accept+3, out_data=4, out_dst=3, mismatch=0, op_count=3.
REQ-035 R1=9, op 001 dst=1 src1=1 src2=1, ALU returns 2 -> R1=2 (wrap), mismatch=0.
REQ-036 R1=7, R2=3, op 110, ALU returns 4'b1011 -> out_data=11, mismatch=1, which stays 1 across later correct operations until rst.
REQ-037 rst asserted in ISSUE of op dst=2 -> R2 stays 0, no out_valid, in_ready=1 next cycle.
REQ-038 in_valid held high across two ALU requests -> in_ready=0 for 3 cycles, second accepted the cycle after WRITE; 256 operations -> op_count wraps to 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external 4-bit ALU: a 4-entry register file, a
// READ/ISSUE/WRITE sequencer, and an internal model that cross-checks each ALU result.
module alu_issue_ctrl #(
    parameter int OPCNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_load,
    input  logic [2:0]         in_op,
    input  logic [1:0]         in_dst,
    input  logic [1:0]         in_src1,
    input  logic [1:0]         in_src2,
    input  logic [3:0]         in_imm,
    output logic [3:0]         alu_rs,
    output logic [3:0]         alu_rt,
    output logic [2:0]         alu_sel,
    input  logic [3:0]         alu_rd,
    output logic               out_valid,
    output logic [3:0]         out_data,
    output logic [1:0]         out_dst,
    output logic               busy,
    output logic               mismatch,
    output logic [OPCNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_ISSUE = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_regs [4];
    logic [1:0] r_dst;
    logic [1:0] r_src1;
    logic [1:0] r_src2;
    logic [2:0] r_op;
    logic [3:0] r_res;
    logic [3:0] w_model;

    // Reference result from the operands currently presented to the ALU.
    always_comb begin
        w_model = 4'd0;
        case (alu_sel)
            3'b000: w_model = alu_rs - alu_rt;
            3'b001: w_model = alu_rs + alu_rt;
            3'b010: w_model = alu_rs | alu_rt;
            3'b011: w_model = alu_rs & alu_rt;
            3'b100: w_model = {alu_rt[0], alu_rt[3:1]};
            3'b101: w_model = {alu_rs[2:0], alu_rs[3]};
            3'b110: w_model = 4'b1010 + {3'b000, (alu_rs < alu_rt)};
            3'b111: w_model = 4'b1110 + {3'b000, (alu_rs == alu_rt)};
            default: w_model = 4'd0;
        endcase
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < 4; i++) r_regs[i] <= 4'd0;
            r_dst     <= 2'd0;
            r_src1    <= 2'd0;
            r_src2    <= 2'd0;
            r_op      <= 3'd0;
            r_res     <= 4'd0;
            alu_rs    <= 4'd0;
            alu_rt    <= 4'd0;
            alu_sel   <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            out_dst   <= 2'd0;
            mismatch  <= 1'b0;
            op_count  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dst <= in_dst;
                        if (in_load) begin
                            // Loads bypass the ALU entirely; alu_* keep their values.
                            r_res   <= in_imm;
                            r_state <= S_WRITE;
                        end else begin
                            r_src1  <= in_src1;
                            r_src2  <= in_src2;
                            r_op    <= in_op;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    alu_rs  <= r_regs[r_src1];
                    alu_rt  <= r_regs[r_src2];
                    alu_sel <= r_op;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_res <= alu_rd;
                    if (alu_rd != w_model) mismatch <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_regs[r_dst] <= r_res;
                    out_valid     <= 1'b1;
                    out_data      <= r_res;
                    out_dst       <= r_dst;
                    op_count      <= op_count + OPCNT_W'(1);
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a bench-side ALU, a register-file reference
// model and a scoreboard queue of expected {dst,data} write-backs.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_load;
    logic [2:0] in_op;
    logic [1:0] in_dst, in_src1, in_src2;
    logic [3:0] in_imm;
    logic [3:0] alu_rs, alu_rt, alu_rd;
    logic [2:0] alu_sel;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_dst;
    logic       busy, mismatch;
    logic [7:0] op_count;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] tb_r [4];
    logic [7:0] exp_cnt;
    logic       exp_mm;
    logic       force_en;
    logic [3:0] force_val;
    logic [5:0] sb [$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.OPCNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_load(in_load), .in_op(in_op), .in_dst(in_dst), .in_src1(in_src1),
        .in_src2(in_src2), .in_imm(in_imm), .alu_rs(alu_rs), .alu_rt(alu_rt),
        .alu_sel(alu_sel), .alu_rd(alu_rd), .out_valid(out_valid),
        .out_data(out_data), .out_dst(out_dst), .busy(busy),
        .mismatch(mismatch), .op_count(op_count)
    );

    function automatic logic [3:0] ref_alu(input logic [3:0] rs, input logic [3:0] rt,
                                           input logic [2:0] op);
        case (op)
            3'b000: return rs - rt;
            3'b001: return rs + rt;
            3'b010: return rs | rt;
            3'b011: return rs & rt;
            3'b100: return {rt[0], rt[3:1]};
            3'b101: return {rs[2:0], rs[3]};
            3'b110: return (rs < rt) ? 4'b1011 : 4'b1010;
            default: return (rs == rt) ? 4'b1111 : 4'b1110;
        endcase
    endfunction

    assign alu_rd = force_en ? force_val : ref_alu(alu_rs, alu_rt, alu_sel);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every write-back pulse.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                chk("out_data", {28'd0, out_data}, {28'd0, e[3:0]});
                chk("out_dst", {30'd0, out_dst}, {30'd0, e[5:4]});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tb_r[i] = 4'd0;
        exp_cnt = 8'd0;
        exp_mm  = 1'b0;
        sb.delete();
    endtask

    // Reference effect of one request; returns value written.
    task automatic predict(input bit ld, input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] s1, input logic [1:0] s2, input logic [3:0] imm);
        logic [3:0] m, v;
        if (ld) v = imm;
        else begin
            m = ref_alu(tb_r[s1], tb_r[s2], op);
            v = force_en ? force_val : m;
            if (v != m) exp_mm = 1'b1;
        end
        tb_r[dst] = v;
        sb.push_back({dst, v});
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic do_req(input bit ld, input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] s1, input logic [1:0] s2, input logic [3:0] imm);
        logic [3:0] ers, ert;
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_load = ld; in_op = op; in_dst = dst;
        in_src1 = s1; in_src2 = s2; in_imm = imm;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        ers = tb_r[s1];
        ert = tb_r[s2];
        predict(ld, op, dst, s1, s2, imm);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (!ld && n == 2) begin
                chk("alu_rs", {28'd0, alu_rs}, {28'd0, ers});
                chk("alu_rt", {28'd0, alu_rt}, {28'd0, ert});
                chk("alu_sel", {29'd0, alu_sel}, {29'd0, op});
            end
            if (out_valid === 1'b1) break;
        end
        chk("latency", n, ld ? 32'd2 : 32'd4);
        chk("op_count", {24'd0, op_count}, {24'd0, exp_cnt});
        chk("mismatch", {31'd0, mismatch}, {31'd0, exp_mm});
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_op = 3'd0;
        in_dst = 2'd0; in_src1 = 2'd0; in_src2 = 2'd0; in_imm = 4'd0;
        force_en = 1'b0; force_val = 4'd0;

        // Reset state
        do_reset();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {alu_rs, alu_rt, alu_sel, out_valid, out_data, out_dst, mismatch},
            32'd0);
        chk("rst_cnt", {24'd0, op_count}, 32'd0);

        // 7 - 3 through the ALU
        do_req(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd7);
        do_req(1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd3);
        do_req(0, 3'b000, 2'd3, 2'd1, 2'd2, 4'd0);
        chk("cnt_after_three", {24'd0, op_count}, 32'd3);

        // Self-source add with wrap; loads untouched by stale op fields
        do_req(1, 3'b111, 2'd1, 2'd3, 2'd3, 4'd9);
        do_req(0, 3'b001, 2'd1, 2'd1, 2'd1, 4'hF);
        do_req(0, 3'b010, 2'd0, 2'd1, 2'd3, 4'd0);
        do_req(0, 3'b011, 2'd2, 2'd3, 2'd1, 4'd0);
        do_req(0, 3'b100, 2'd3, 2'd0, 2'd3, 4'd0);
        do_req(0, 3'b101, 2'd0, 2'd3, 2'd0, 4'd0);
        do_req(0, 3'b111, 2'd2, 2'd1, 2'd1, 4'd0);

        // Wrong ALU answer for compare; sticky through later correct ops
        do_req(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd7);
        do_req(1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd3);
        force_en = 1'b1; force_val = 4'b1011;
        do_req(0, 3'b110, 2'd0, 2'd1, 2'd2, 4'd0);
        force_en = 1'b0;
        do_req(0, 3'b001, 2'd3, 2'd1, 2'd2, 4'd0);
        do_req(0, 3'b110, 2'd3, 2'd2, 2'd1, 4'd0);
        do_reset();
        chk("mm_cleared", {31'd0, mismatch}, 32'd0);

        // Reset during ISSUE aborts the write to R2
        do_req(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5);
        @(negedge clk);
        in_valid = 1'b1; in_load = 1'b0; in_op = 3'b001;
        in_dst = 2'd2; in_src1 = 2'd1; in_src2 = 2'd1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_issue_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tb_r[i] = 4'd0;
        exp_cnt = 8'd0; exp_mm = 1'b0;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_out", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        do_req(0, 3'b001, 2'd3, 2'd2, 2'd1, 4'd0);

        // in_valid held high: second request waits out READ/ISSUE/WRITE
        do_req(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd6);
        do_req(1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd4);
        @(negedge clk);
        in_valid = 1'b1; in_load = 1'b0; in_op = 3'b001;
        in_dst = 2'd0; in_src1 = 2'd1; in_src2 = 2'd2;
        predict(0, 3'b001, 2'd0, 2'd1, 2'd2, 4'd0);
        @(posedge clk);
        #1 in_op = 3'b000; in_dst = 2'd3; in_src1 = 2'd0; in_src2 = 2'd1;
        predict(0, 3'b000, 2'd3, 2'd0, 2'd1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("held_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        chk("held_ready_back", {31'd0, in_ready}, 32'd1);
        chk("held_first_done", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk("held_second_done", {31'd0, out_valid}, 32'd1);
        chk("held_cnt", {24'd0, op_count}, {24'd0, exp_cnt});

        // 256 completions wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++)
            do_req(1, 3'($urandom_range(7)), 2'(i), 2'd0, 2'd0, 4'($urandom_range(15)));
        chk("cnt_wrap", {24'd0, op_count}, 32'd0);

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        chk("timeout", 32'd1, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "FAIL timeout");
    end

endmodule
